// File: rtl/vga_frame_writer_pkg.sv
// rtl/vga_frame_writer_pkg.sv - shared frame-buffer geometry and byte-pack state encoding
// Purpose: constants shared by the VGA display reader and the frame writer, the
//          byte-pack FSM state type, and the RGB565 expansion helper.
// Build option: FRAME_WR_RGB565_EN selects 2-byte RGB565 pixels instead of RGB888.
// Ports: none (package).
package vga_frame_writer_pkg;

  localparam int DEF_IMG_W  = 400;
  localparam int DEF_IMG_H  = 300;
  localparam int FB_DEPTH   = DEF_IMG_W * DEF_IMG_H;
  localparam int FB_ADDR_W  = 17;

`ifdef FRAME_WR_RGB565_EN
  typedef enum logic {
    S_HI = 1'b0,
    S_LO = 1'b1
  } state_t;

  localparam state_t S_FIRST = S_HI;
  localparam state_t S_LAST  = S_LO;

  // Low bits are filled with ones so full-scale 565 maps to full-scale 888.
  function automatic logic [23:0] rgb565_expand(input logic [15:0] p);
    return {p[15:11], 3'b111, p[10:5], 2'b11, p[4:0], 3'b111};
  endfunction
`else
  typedef enum logic [1:0] {
    S_R = 2'd0,
    S_G = 2'd1,
    S_B = 2'd2
  } state_t;

  localparam state_t S_FIRST = S_R;
  localparam state_t S_LAST  = S_B;
`endif

endpackage

// File: rtl/vga_frame_writer_fb_addr_counter.sv
// rtl/vga_frame_writer_fb_addr_counter.sv - linear frame-buffer pixel address counter
// Purpose: holds the next pixel address; clears on restart, steps on each written
//          pixel and wraps to 0 after the last pixel of the frame.
// Ports:
//   clk_25m  in   system clock
//   rst_n    in   asynchronous active-low reset
//   clr      in   force address to 0 (takes priority over inc)
//   inc      in   advance by one pixel, wrapping at DEPTH-1
//   addr     out  current pixel address (col + row*IMG_W by construction)
//   last     out  addr is the final pixel of the frame
module vga_frame_writer_fb_addr_counter #(
  parameter int DEPTH  = vga_frame_writer_pkg::FB_DEPTH,
  parameter int ADDR_W = vga_frame_writer_pkg::FB_ADDR_W
) (
  input  logic              clk_25m,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  assign last = (addr == LAST_ADDR);

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (clr) begin
      addr <= '0;
    end else if (inc) begin
      addr <= last ? '0 : addr + 1'b1;
    end
  end

endmodule

// File: rtl/vga_frame_writer.sv
// rtl/vga_frame_writer.sv - packs a loader byte stream into frame-buffer pixel writes
// Purpose: assembles bytes into 24-bit pixels and writes them at linear addresses,
//          with a frame-complete pulse and a sticky restart-error flag.
// Build option: FRAME_WR_RGB565_EN packs 2-byte RGB565 pixels (default: 3-byte RGB888).
// Ports:
//   clk_25m     in   system clock
//   rst_n       in   asynchronous active-low reset
//   sof         in   start-of-frame, qualified by byte_valid
//   byte_valid  in   pix_byte valid this cycle
//   pix_byte    in   stream byte, colour MSB first
//   wr_en       out  frame-buffer write strobe, one cycle per pixel
//   wr_addr     out  frame-buffer write address
//   wr_data     out  pixel {R,G,B}
//   frame_done  out  pulse alongside the write of the last pixel
//   sof_err     out  sticky: frame restarted mid-pixel or mid-frame
module vga_frame_writer #(
  parameter int IMG_W  = vga_frame_writer_pkg::DEF_IMG_W,
  parameter int IMG_H  = vga_frame_writer_pkg::DEF_IMG_H,
  parameter int ADDR_W = vga_frame_writer_pkg::FB_ADDR_W
) (
  input  logic              clk_25m,
  input  logic              rst_n,
  input  logic              sof,
  input  logic              byte_valid,
  input  logic [7:0]        pix_byte,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              frame_done,
  output logic              sof_err
);

  import vga_frame_writer_pkg::*;

  localparam int DEPTH = IMG_W * IMG_H;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt_addr;
  logic              cnt_last;
  logic              restart;
  logic              pix_done;
  logic [23:0]       pix_word;
  logic [7:0]        byte0;
`ifndef FRAME_WR_RGB565_EN
  logic [7:0]        byte1;
`endif

  // A qualified sof always starts a new pixel 0, even if it lands on what
  // would otherwise be the closing byte of a pixel.
  assign restart  = sof && byte_valid;
  assign pix_done = byte_valid && !sof && (state == S_LAST);

`ifdef FRAME_WR_RGB565_EN
  assign pix_word = rgb565_expand({byte0, pix_byte});
`else
  assign pix_word = {byte0, byte1, pix_byte};
`endif

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FIRST;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (byte_valid) begin
`ifdef FRAME_WR_RGB565_EN
      if (sof) begin
        state_nxt = S_LO;
      end else begin
        state_nxt = (state == S_HI) ? S_LO : S_HI;
      end
`else
      if (sof) begin
        state_nxt = S_G;
      end else begin
        case (state)
          S_R:     state_nxt = S_G;
          S_G:     state_nxt = S_B;
          default: state_nxt = S_R;
        endcase
      end
`endif
    end
  end

  // Partial-pixel byte capture; holds while byte_valid is low.
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      byte0 <= '0;
`ifndef FRAME_WR_RGB565_EN
      byte1 <= '0;
`endif
    end else if (byte_valid) begin
      if (sof || state == S_FIRST) begin
        byte0 <= pix_byte;
      end
`ifndef FRAME_WR_RGB565_EN
      if (!sof && state == S_G) begin
        byte1 <= pix_byte;
      end
`endif
    end
  end

  vga_frame_writer_fb_addr_counter #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_addr_cnt (
    .clk_25m (clk_25m),
    .rst_n   (rst_n),
    .clr     (restart),
    .inc     (pix_done),
    .addr    (cnt_addr),
    .last    (cnt_last)
  );

  // Write port is registered: the write lands one cycle after the closing byte,
  // using the counter value from before its increment.
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
    end else begin
      wr_en      <= pix_done;
      frame_done <= pix_done && cnt_last;
      if (pix_done) begin
        wr_addr <= cnt_addr;
        wr_data <= pix_word;
      end
      if (restart && (state != S_FIRST || cnt_addr != '0)) begin
        sof_err <= 1'b1;
      end
    end
  end

endmodule
